syst_ws_array: RTL and testbench



---
 rtl/syst_ws_pkg.sv | 14 +
 rtl/syst_ws_pe.sv | 58 +++++
 rtl/syst_ws_array.sv | 104 ++++++++++
 tb/tb_syst_ws_array.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/syst_ws_pkg.sv
// Shared sizing constants and the fixed weight map for the 5x5 weight-stationary array.
package syst_ws_pkg;

    localparam int N      = 5;
    localparam int DATA_W = 8;
    localparam int PROD_W = 16;
    localparam int PSUM_W = 20;

    // Rows and columns are 1-based here so the map reads w(r,c) = r*r + c directly.
    function automatic logic [DATA_W-1:0] weight(input int r, input int c);
        return DATA_W'(r * r + c);
    endfunction

endpackage

// File: rtl/syst_ws_pe.sv
// One weight-stationary processing element: passes activations right and
// accumulates its weighted activation into the partial sum moving down.
module syst_ws_pe
    import syst_ws_pkg::*;
#(
    parameter logic [DATA_W-1:0] WEIGHT = 8'd1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] x_i,
    input  logic              xv_i,
    input  logic [PSUM_W-1:0] ps_i,
    input  logic              pv_i,
    output logic [DATA_W-1:0] x_o,
    output logic              xv_o,
    output logic [PSUM_W-1:0] ps_o,
    output logic              pv_o
);

    logic [PROD_W-1:0] prod_s;
    logic [PSUM_W-1:0] sum_s;
    logic [DATA_W-1:0] x_r;
    logic              xv_r;
    logic [PSUM_W-1:0] ps_r;
    logic              pv_r;

    // Masked product added onto the incoming partial sum; the sum wraps at PSUM_W bits.
    always_comb begin
        prod_s = {PROD_W{1'b0}};
        if (xv_i) begin
            prod_s = PROD_W'(x_i) * PROD_W'(WEIGHT);
        end else begin
            prod_s = {PROD_W{1'b0}};
        end
        sum_s = ps_i + PSUM_W'(prod_s);
    end

    // Activation, partial-sum and valid pipeline registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_r  <= {DATA_W{1'b0}};
            xv_r <= 1'b0;
            ps_r <= {PSUM_W{1'b0}};
            pv_r <= 1'b0;
        end else begin
            x_r  <= x_i;
            xv_r <= xv_i;
            ps_r <= sum_s;
            pv_r <= pv_i | xv_i;
        end
    end

    assign x_o  = x_r;
    assign xv_o = xv_r;
    assign ps_o = ps_r;
    assign pv_o = pv_r;

endmodule

// File: rtl/syst_ws_array.sv
// 5x5 weight-stationary systolic matrix-vector engine; callers skew row r by r-1 cycles
// and each column sum lands in a hold register at the bottom.
module syst_ws_array
    import syst_ws_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] x1_i,
    input  logic [DATA_W-1:0] x2_i,
    input  logic [DATA_W-1:0] x3_i,
    input  logic [DATA_W-1:0] x4_i,
    input  logic [DATA_W-1:0] x5_i,
    input  logic              valid1_i,
    input  logic              valid2_i,
    input  logic              valid3_i,
    input  logic              valid4_i,
    input  logic              valid5_i,
    output logic [PSUM_W-1:0] y1_o,
    output logic [PSUM_W-1:0] y2_o,
    output logic [PSUM_W-1:0] y3_o,
    output logic [PSUM_W-1:0] y4_o,
    output logic [PSUM_W-1:0] y5_o
);

    // x_s/xv_s[r][c] feed PE(r,c); ps_s/pv_s[r][c] feed PE(r,c) and row N is the bottom edge.
    logic [DATA_W-1:0] x_s  [N][N];
    logic              xv_s [N][N];
    logic [PSUM_W-1:0] ps_s [N+1][N];
    logic              pv_s [N+1][N];
    logic [PSUM_W-1:0] y_r  [N];

    assign x_s[0][0]  = x1_i;
    assign x_s[1][0]  = x2_i;
    assign x_s[2][0]  = x3_i;
    assign x_s[3][0]  = x4_i;
    assign x_s[4][0]  = x5_i;
    assign xv_s[0][0] = valid1_i;
    assign xv_s[1][0] = valid2_i;
    assign xv_s[2][0] = valid3_i;
    assign xv_s[3][0] = valid4_i;
    assign xv_s[4][0] = valid5_i;

    for (genvar c = 0; c < N; c++) begin : g_top
        assign ps_s[0][c] = {PSUM_W{1'b0}};
        assign pv_s[0][c] = 1'b0;
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            if (c < N - 1) begin : g_pass
                syst_ws_pe #(.WEIGHT(weight(r + 1, c + 1))) u_pe (
                    .clk_i (clk_i),
                    .rst_i (rst_i),
                    .x_i   (x_s[r][c]),
                    .xv_i  (xv_s[r][c]),
                    .ps_i  (ps_s[r][c]),
                    .pv_i  (pv_s[r][c]),
                    .x_o   (x_s[r][c+1]),
                    .xv_o  (xv_s[r][c+1]),
                    .ps_o  (ps_s[r+1][c]),
                    .pv_o  (pv_s[r+1][c])
                );
            end else begin : g_edge
                // Rightmost column: activations leave the array here.
                syst_ws_pe #(.WEIGHT(weight(r + 1, c + 1))) u_pe (
                    .clk_i (clk_i),
                    .rst_i (rst_i),
                    .x_i   (x_s[r][c]),
                    .xv_i  (xv_s[r][c]),
                    .ps_i  (ps_s[r][c]),
                    .pv_i  (pv_s[r][c]),
                    .x_o   (),
                    .xv_o  (),
                    .ps_o  (ps_s[r+1][c]),
                    .pv_o  (pv_s[r+1][c])
                );
            end
        end
    end

    // Column result registers: load on a valid bottom partial sum, otherwise hold.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < N; c++) begin
                y_r[c] <= {PSUM_W{1'b0}};
            end
        end else begin
            for (int c = 0; c < N; c++) begin
                if (pv_s[N][c]) begin
                    y_r[c] <= ps_s[N][c];
                end else begin
                    y_r[c] <= y_r[c];
                end
            end
        end
    end

    assign y1_o = y_r[0];
    assign y2_o = y_r[1];
    assign y3_o = y_r[2];
    assign y4_o = y_r[3];
    assign y5_o = y_r[4];

endmodule

// File: tb/tb_syst_ws_array.sv
// Self-checking bench for syst_ws_array: table-driven skewed waves with a
// scoreboard of expected column results keyed by the edge at which they appear.
module tb_syst_ws_array;

    typedef struct packed {
        logic [4:0][7:0]  x;
        logic [4:0]       v;
        logic [4:0][19:0] y;
    } vec_t;

    typedef struct {
        int          due;
        int          col;
        logic [19:0] val;
    } sb_t;

    logic        clk;
    logic        rst;
    logic [7:0]  xd [5];
    logic        vd [5];
    logic [19:0] yo [5];

    int          n_chk;
    int          n_fail;
    string       phase;
    logic [19:0] exp_y [5];
    sb_t         sbq [$];
    vec_t        tbl [5];
    vec_t        w_vec [8];
    int          w_start [8];
    int          n_waves;
    int          rst_cyc;

    syst_ws_array dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .x1_i     (xd[0]),
        .x2_i     (xd[1]),
        .x3_i     (xd[2]),
        .x4_i     (xd[3]),
        .x5_i     (xd[4]),
        .valid1_i (vd[0]),
        .valid2_i (vd[1]),
        .valid3_i (vd[2]),
        .valid4_i (vd[3]),
        .valid5_i (vd[4]),
        .y1_o     (yo[0]),
        .y2_o     (yo[1]),
        .y3_o     (yo[2]),
        .y4_o     (yo[3]),
        .y5_o     (yo[4])
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %0d expected %0d", phase, name, act, exp);
        end
    endtask

    // Reference result: sum over valid rows of x_r * (r*r + c), rows/cols 1-based.
    function automatic logic [19:0] model_y(input vec_t vv, input int c);
        logic [19:0] acc;
        acc = 20'd0;
        for (int r = 0; r < 5; r++) begin
            if (vv.v[r]) acc = acc + 20'(vv.x[r]) * 20'((r + 1) * (r + 1) + c + 1);
        end
        return acc;
    endfunction

    // Drives the scheduled waves with row skew for len cycles, checking every output each cycle.
    task automatic run_phase(input int len);
        for (int cyc = 0; cyc < len; cyc++) begin
            @(negedge clk);
            for (int r = 0; r < 5; r++) begin
                xd[r] = 8'd0;
                vd[r] = 1'b0;
            end
            for (int w = 0; w < n_waves; w++) begin
                for (int r = 0; r < 5; r++) begin
                    if ((w_start[w] + r == cyc) && (rst_cyc < 0 || cyc < rst_cyc)) begin
                        xd[r] = w_vec[w].x[r];
                        vd[r] = w_vec[w].v[r];
                    end
                end
                if (w_start[w] == cyc && (|w_vec[w].v)) begin
                    for (int c = 0; c < 5; c++) begin
                        sbq.push_back('{w_start[w] + 5 + c, c, w_vec[w].y[c]});
                    end
                end
            end
            rst = (cyc == rst_cyc);
            @(posedge clk);
            #1;
            if (cyc == rst_cyc) begin
                sbq.delete();
                for (int c = 0; c < 5; c++) exp_y[c] = 20'd0;
            end else begin
                for (int i = sbq.size() - 1; i >= 0; i--) begin
                    if (sbq[i].due == cyc) begin
                        exp_y[sbq[i].col] = sbq[i].val;
                        sbq.delete(i);
                    end
                end
            end
            for (int c = 0; c < 5; c++) begin
                check($sformatf("y%0d cyc%0d", c + 1, cyc), yo[c], exp_y[c]);
            end
        end
        rst = 1'b0;
        n_chk++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL %s scoreboard_drain: got %0d pending expected 0", phase, sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        clk     = 1'b0;
        rst     = 1'b1;
        n_waves = 0;
        rst_cyc = -1;
        for (int r = 0; r < 5; r++) begin
            xd[r] = 8'd0;
            vd[r] = 1'b0;
        end

        tbl[0].x = {8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
        tbl[0].v = 5'b11111;
        tbl[0].y = {20'd80, 20'd75, 20'd70, 20'd65, 20'd60};
        tbl[1].x = {8'd1, 8'd2, 8'd2, 8'd2, 8'd2};
        tbl[1].v = 5'b11101;
        tbl[1].y = {20'd112, 20'd105, 20'd98, 20'd91, 20'd84};
        tbl[2].x = {8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        tbl[2].v = 5'b11111;
        tbl[2].y = {20'd20400, 20'd19125, 20'd17850, 20'd16575, 20'd15300};
        tbl[3].x = {8'd9, 8'd7, 8'd5, 8'd3, 8'd1};
        tbl[3].v = 5'b00000;
        tbl[3].y = {20'd0, 20'd0, 20'd0, 20'd0, 20'd0};
        tbl[4].x = {8'd2, 8'd2, 8'd2, 8'd2, 8'd2};
        tbl[4].v = 5'b11111;
        tbl[4].y = {20'd160, 20'd150, 20'd140, 20'd130, 20'd120};

        phase = "reset";
        @(negedge clk);
        for (int r = 0; r < 5; r++) begin
            xd[r] = 8'($urandom_range(0, 255));
            vd[r] = 1'($urandom_range(0, 1));
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 5; c++) begin
            exp_y[c] = 20'd0;
            check($sformatf("y%0d after reset", c + 1), yo[c], exp_y[c]);
        end
        rst = 1'b0;
        phase = "idle";
        run_phase(6);

        for (int k = 0; k < 5; k++) begin
            phase      = $sformatf("table%0d", k);
            n_waves    = 1;
            w_start[0] = 0;
            w_vec[0]   = tbl[k];
            rst_cyc    = -1;
            run_phase(12);
        end

        phase      = "back_to_back";
        n_waves    = 2;
        w_start[0] = 0;
        w_vec[0]   = tbl[0];
        w_start[1] = 1;
        w_vec[1]   = tbl[4];
        run_phase(12);

        phase   = "random_stream";
        n_waves = 6;
        for (int w = 0; w < 6; w++) begin
            w_start[w] = w;
            for (int r = 0; r < 5; r++) w_vec[w].x[r] = 8'($urandom_range(0, 255));
            w_vec[w].v = 5'($urandom_range(0, 31));
            for (int c = 0; c < 5; c++) w_vec[w].y[c] = model_y(w_vec[w], c);
        end
        run_phase(18);

        phase      = "midflight_reset";
        n_waves    = 1;
        w_start[0] = 0;
        w_vec[0]   = tbl[2];
        rst_cyc    = 2;
        run_phase(14);
        rst_cyc    = -1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
